// File: rtl/spi_slave_if.sv
// SPI pin bundle between the link master and the spi_slave endpoint.
// sclk idles high, cs is active low, miso is always driven by the slave.
interface spi_slave_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI peripheral: 1 flag bit + 8 data bits, LSB first, byte-level rx/tx.
// Optional abort reporting on frame_err is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave (
    input  logic        clk,
    input  logic        reset_n,
    spi_slave_if.slave  spi,
    input  logic [7:0]  tx_data,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        tx_done,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, FLAG, DATA, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        cs_s1, cs_s2;
    logic        mosi_s1, mosi_s2;
    logic        sclk_fall;
    logic        flag;
    logic        miso_bit;
    logic [2:0]  bitcnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;

    // Synchronizers idle at the inactive pin levels so reset never fakes an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_s3 <= 1'b1;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= spi.cs;
            cs_s2   <= cs_s1;
            mosi_s1 <= spi.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_fall = sclk_s3 & ~sclk_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A released cs always wins over a coincident sclk fall
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!cs_s2) next_state = FLAG;
            FLAG: begin
                if (cs_s2)          next_state = IDLE;
                else if (sclk_fall) next_state = DATA;
            end
            DATA: begin
                if (cs_s2)                            next_state = IDLE;
                else if (sclk_fall && bitcnt == 3'd7) next_state = DONE;
            end
            DONE: if (cs_s2) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag     <= 1'b0;
            miso_bit <= 1'b0;
            bitcnt   <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    bitcnt <= 3'd0;
                    flag   <= 1'b0;
                end
                FLAG: begin
                    if (!cs_s2 && sclk_fall) begin
                        flag <= mosi_s2;
                        if (mosi_s2) begin
                            miso_bit <= tx_data[0];
                            tx_shift <= {1'b0, tx_data[7:1]};
                        end
                    end
                end
                DATA: begin
                    if (!cs_s2 && sclk_fall) begin
                        rx_shift <= {mosi_s2, rx_shift[7:1]};
                        bitcnt   <= bitcnt + 3'd1;
                        if (flag) begin
                            miso_bit <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                        // Pulses land in the first DONE cycle
                        if (bitcnt == 3'd7) begin
                            if (flag) begin
                                tx_done <= 1'b1;
                            end else begin
                                rx_data  <= {mosi_s2, rx_shift[7:1]};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating keeps miso low in IDLE and on write frames, including straight out of reset
    assign spi.miso = (state != IDLE) && flag && miso_bit;
    assign busy     = (state != IDLE);

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_err <= 1'b0;
        else          frame_err <= cs_s2 && ((state == FLAG) || (state == DATA));
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, hand sequences, random frames vs. a byte-level model.
module tb_spi_slave;

    localparam int HALF = 9;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    localparam int FE_EN = 1;
`else
    localparam int FE_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_done, busy, frame_err;

    spi_slave_if spi ();

    spi_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi       (spi.slave),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rv_cnt = 0, td_cnt = 0, fe_cnt = 0, miso_hi = 0;
    logic [7:0] last_rx = 8'h00;

    // Pulse counters; a pulse held for two cycles counts twice
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt  <= rv_cnt + 1;
            last_rx <= rx_data;
        end
        if (tx_done)   td_cnt  <= td_cnt + 1;
        if (frame_err) fe_cnt  <= fe_cnt + 1;
        if (spi.miso)  miso_hi <= miso_hi + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bit-bangs one frame; nbits < 8 releases cs early to abort
    task automatic applyStimulus(input logic f, input logic [7:0] d, input int nbits, output logic [7:0] cap);
        cap = 8'h00;
        spi.mosi = f;
        spi.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k <= nbits; k++) begin
            spi.sclk = 1'b0;
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b1;
            if (k < 8) begin
                cap[k] = spi.miso;
                spi.mosi = d[k];
            end
            repeat (HALF) @(negedge clk);
        end
        spi.cs = 1'b1;
        spi.mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    typedef struct {
        logic       flag;
        logic [7:0] data;
        logic [7:0] tx;
        int         nbits;
        logic [7:0] exp_rx;
        logic [7:0] exp_cap;
        int         exp_rv;
        int         exp_td;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];

    task automatic runFrame(input string tag, input logic f, input logic [7:0] d, input logic [7:0] tx,
                            input int nbits, input logic [7:0] exp_rx, input logic [7:0] exp_cap,
                            input int exp_rv, input int exp_td, input int exp_fe);
        int rv0, td0, fe0, mh0;
        logic [7:0] cap;
        rv0 = rv_cnt; td0 = td_cnt; fe0 = fe_cnt; mh0 = miso_hi;
        tx_data = tx;
        applyStimulus(f, d, nbits, cap);
        checkOutput({tag, " rx_data"}, rx_data, exp_rx);
        checkOutput({tag, " rx_valid cycles"}, rv_cnt - rv0, exp_rv);
        checkOutput({tag, " tx_done cycles"}, td_cnt - td0, exp_td);
        checkOutput({tag, " frame_err cycles"}, fe_cnt - fe0, exp_fe * FE_EN);
        checkOutput({tag, " busy after"}, busy, 1'b0);
        if (exp_rv > 0) checkOutput({tag, " rx byte at valid"}, last_rx, exp_rx);
        if (!f) checkOutput({tag, " miso high cycles"}, miso_hi - mh0, 0);
        if (f && nbits == 8) checkOutput({tag, " miso captured"}, cap, exp_cap);
    endtask

    initial begin
        logic [7:0] model_rx;
        logic       rf;
        logic [7:0] rd, rt;
        int         rn, bc0;

        spi.sclk = 1'b1;
        spi.cs   = 1'b1;
        spi.mosi = 1'b0;

        vecs[0] = '{1'b0, 8'hA5, 8'h00, 8, 8'hA5, 8'h00, 1, 0, 0};
        vecs[1] = '{1'b1, 8'h00, 8'h3C, 8, 8'hA5, 8'h3C, 0, 1, 0};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 4, 8'hA5, 8'h00, 0, 0, 1};
        vecs[3] = '{1'b0, 8'h01, 8'h00, 8, 8'h01, 8'h00, 1, 0, 0};
        vecs[4] = '{1'b0, 8'h80, 8'h00, 8, 8'h80, 8'h00, 1, 0, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset rx_data", rx_data, 8'h00);
        checkOutput("reset rx_valid", rx_valid, 1'b0);
        checkOutput("reset tx_done", tx_done, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset miso", spi.miso, 1'b0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // busy latency: third clk edge after cs falls
        spi.cs = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("busy after 2 edges", busy, 1'b0);
        @(posedge clk); #1;
        checkOutput("busy after 3 edges", busy, 1'b1);
        @(negedge clk);
        spi.cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        for (int i = 0; i < 5; i++)
            runFrame($sformatf("vec%0d", i), vecs[i].flag, vecs[i].data, vecs[i].tx, vecs[i].nbits,
                     vecs[i].exp_rx, vecs[i].exp_cap, vecs[i].exp_rv, vecs[i].exp_td, vecs[i].exp_fe);

        // sclk activity with cs high must be ignored
        bc0 = rv_cnt + td_cnt + fe_cnt;
        for (int i = 0; i < 12; i++) begin
            spi.sclk = 1'b0; spi.mosi = i[0];
            repeat (HALF) @(negedge clk);
            checkOutput("idle sclk busy", busy, 1'b0);
            spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        spi.mosi = 1'b0;
        checkOutput("idle sclk pulses", rv_cnt + td_cnt + fe_cnt - bc0, 0);
        checkOutput("idle sclk rx_data", rx_data, 8'h80);

        // reset in the middle of a read frame
        tx_data = 8'hFF;
        spi.mosi = 1'b1;
        spi.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            spi.sclk = 1'b0; repeat (HALF) @(negedge clk);
            spi.sclk = 1'b1; repeat (HALF) @(negedge clk);
        end
        checkOutput("mid-read miso", spi.miso, 1'b1);
        checkOutput("mid-read busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset mid-read miso", spi.miso, 1'b0);
        checkOutput("reset mid-read busy", busy, 1'b0);
        spi.cs = 1'b1;
        spi.mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        runFrame("post-reset 5A", 1'b0, 8'h5A, 8'h00, 8, 8'h5A, 8'h00, 1, 0, 0);

        // random frames against a byte-level model
        model_rx = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            rf = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rt = 8'($urandom);
            rn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8;
            if (rn == 8 && !rf) model_rx = rd;
            runFrame($sformatf("rand%0d", i), rf, rd, rt, rn, model_rx, rt,
                     (rn == 8 && !rf) ? 1 : 0, (rn == 8 && rf) ? 1 : 0, (rn < 8) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
